draw_text_box: RTL and testbench
================================

Name: draw_text_box

Overview:
- Consumer side of the text-ROM interface. It generates `char_xy` addresses from the VGA timing stream and takes back the registered `char_code`.
- It then looks up the 8x16 font bitmap and overlays the glyph pixels onto the incoming RGB stream.
- It sits in the draw chain after the background/board stage and before VGA out. One instance is used per text ROM, for example the win/lose banners.

Parameters:
- X_POS, 0, left pixel column of the text box.
- Y_POS, 0, top pixel row of the text box.
- COLS, 16, characters per text row (1..16).
- ROWS, 1, text rows (1..16).
- TXT_COLOR, 12'hFFF, 12-bit RGB colour of glyph pixels.
- BG_COLOR, 12'h000, box background colour (used only with TXT_BG_EN).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- hcount_in  in  11  horizontal pixel counter.
- vcount_in  in  11  vertical pixel counter.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA timing.
- rgb_in  in  12  upstream pixel colour.
- char_xy  out  8  text-ROM address: [7:4] text row, [3:0] text column.
- char_code  in  7  text-ROM data, valid one cycle after `char_xy`.
- font_addr  out  11  font-ROM address {char_code, glyph_row[3:0]}.
- font_data  in  8  font-ROM row bitmap, valid one cycle after `font_addr`; bit 7 is the leftmost pixel.
- hcount_out, vcount_out  out  11 each  timing delayed by 3 cycles.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  timing delayed by 3 cycles.
- rgb_out  out  12  composed pixel.

Behaviour:
- Interface: one clock `clk`; `rst_n` is asynchronous, active-low.
- Cycle 0: compute `rel_x = hcount_in - X_POS` and `rel_y = vcount_in - Y_POS`, both 11-bit unsigned with wrap.
  - `in_box` = (`hcount_in` >= X_POS) && (`hcount_in` < X_POS + 8*COLS) && (`vcount_in` >= Y_POS) && (`vcount_in` < Y_POS + 16*ROWS).
  - `char_xy` = {`rel_y[7:4]`, `rel_x[6:3]`}, driven combinationally. Outside the box it is forced to 8'h00.
- Stage 1 register captures timing, `rgb_in`, `in_box`, `rel_x[2:0]` and `rel_y[3:0]`. `font_addr` = {`char_code`, stage-1 `rel_y[3:0]`}, driven combinationally.
- Stage 2 register captures timing, rgb, `in_box` and `rel_x[2:0]`. Pixel bit = `font_data[7 - rel_x[2:0]]`.
- Stage 3 output register:
  - `rgb_out` = TXT_COLOR when `in_box` && pixel bit && !(hblnk|vblnk).
  - Otherwise `rgb_out` = delayed rgb.
  - All timing outputs are driven from this register.
- Total latency is 3 cycles for every output. The pipeline is fully streaming: one pixel per cycle, no stalls, no handshake.
- Boundary conditions:
  - Columns X_POS+8*COLS-1 and Y_POS+16*ROWS-1 are inside the box; the next pixel is outside.
  - COLS=16 / ROWS=16 use the full address space without aliasing.
  - X_POS near 2047 is not supported; the parameter must satisfy X_POS+8*COLS <= 2048.
  - A space glyph (all-zero font row) passes `rgb_in` through.
- Reset:
  - Every pipeline register and every output goes to 0. `rgb_out` = 12'h000; hsync/vsync/blank outputs = 0.
  - Asserting `rst_n` low mid-frame clears the pipeline immediately.
  - On release, the first valid output appears 3 cycles after the first sampled input.

Optional Feature:
- Macro: `DRAW_TEXT_BG_EN`.
- Defined: an in-box, non-glyph, non-blank pixel outputs BG_COLOR, giving an opaque text box.
- Undefined: non-glyph pixels pass through the delayed rgb (transparent box), and BG_COLOR is unused.

Decomposition:
- Shared package `draw_text_pkg`:
  - CHAR_W=8, CHAR_H=16, FONT_ADDR_W=11, CHAR_CODE_W=7.
  - Typedef `char_xy_t` (packed: row[3:0], col[3:0]).
- Sub-module `delay_pipe`: parameterised width/depth register chain with async active-low reset, used for the timing/rgb delay lines.

Test Plan:
- Reset: hold `rst_n`=0 with random inputs -> all outputs 0. Release -> first input echoed on outputs exactly 3 cycles later.
- X_POS=100, Y_POS=50, `hcount_in`=117, `vcount_in`=53 -> `char_xy`=8'h02 the same cycle; `font_addr`={code,4'd3} one cycle later.
- Font model returns 8'b1000_0000 for row 3; pixels hcount=116 and 117 -> only 116 produces TXT_COLOR on `rgb_out` 3 cycles later; 117 passes `rgb_in`.
- Edges with COLS=16: hcount=227 -> in box; hcount=228 -> pass-through and `char_xy`=8'h00. Same check on the bottom row edge.
- Blanking: glyph pixel with `hblnk_in`=1 -> `rgb_out` = delayed `rgb_in`, never TXT_COLOR.
- With `DRAW_TEXT_BG_EN`, BG_COLOR=12'h00F, space glyph inside the box -> `rgb_out`=12'h00F. Without the macro -> `rgb_in` passes through.

Source files
------------

// File: rtl/draw_text_pkg.sv
// Shared constants and types for the text-box overlay.
// Geometry of the 8x16 font and the VGA bundle carried down the pipe.
package draw_text_pkg;

   localparam int CHAR_W      = 8;
   localparam int CHAR_H      = 16;
   localparam int FONT_ADDR_W = 11;
   localparam int CHAR_CODE_W = 7;
   localparam int CNT_W       = 11;
   localparam int RGB_W       = 12;

   typedef struct packed {
      logic [3:0] row;
      logic [3:0] col;
   } char_xy_t;

   typedef struct packed {
      logic [CNT_W-1:0] hcount;
      logic [CNT_W-1:0] vcount;
      logic             hsync;
      logic             vsync;
      logic             hblnk;
      logic             vblnk;
      logic [RGB_W-1:0] rgb;
   } vga_t;

   // Bit 7 of a font row is the leftmost pixel.
   function automatic logic glyph_bit(
      input logic [7:0] row,
      input logic [2:0] col
   );
      return row[3'd7 - col];
   endfunction

endpackage

// File: rtl/draw_text_box_delay_pipe.sv
// Fixed-depth register chain for timing/colour delay lines.
// Every stage clears on the asynchronous active-low reset.
module delay_pipe #(
   parameter int W = 1,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] pipe_q [D];

   // Shift the input one stage per clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < D; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < D; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign q_o = pipe_q[D-1];

endmodule

// File: rtl/draw_text_box.sv
// Text-box overlay: text-ROM address, font lookup, glyph compose.
// Optional opaque background when DRAW_TEXT_BG_EN is defined.
module draw_text_box
   import draw_text_pkg::*;
#(
   parameter int         X_POS     = 0,
   parameter int         Y_POS     = 0,
   parameter int         COLS      = 16,
   parameter int         ROWS      = 1,
   parameter logic [11:0] TXT_COLOR = 12'hFFF,
   parameter logic [11:0] BG_COLOR  = 12'h000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [CNT_W-1:0]       hcount_in,
   input  logic [CNT_W-1:0]       vcount_in,
   input  logic                   hsync_in,
   input  logic                   vsync_in,
   input  logic                   hblnk_in,
   input  logic                   vblnk_in,
   input  logic [RGB_W-1:0]       rgb_in,
   output logic [7:0]             char_xy,
   input  logic [CHAR_CODE_W-1:0] char_code,
   output logic [FONT_ADDR_W-1:0] font_addr,
   input  logic [7:0]             font_data,
   output logic [CNT_W-1:0]       hcount_out,
   output logic [CNT_W-1:0]       vcount_out,
   output logic                   hsync_out,
   output logic                   vsync_out,
   output logic                   hblnk_out,
   output logic                   vblnk_out,
   output logic [RGB_W-1:0]       rgb_out
);

`ifdef DRAW_TEXT_BG_EN
   localparam bit BG_EN = 1'b1;
`else
   localparam bit BG_EN = 1'b0;
`endif

   // Box bounds in 12 bits so X_POS+8*COLS == 2048 does not wrap.
   localparam logic [11:0] X_LO  = 12'(X_POS);
   localparam logic [11:0] X_HI  = 12'(X_POS + CHAR_W * COLS);
   localparam logic [11:0] Y_LO  = 12'(Y_POS);
   localparam logic [11:0] Y_HI  = 12'(Y_POS + CHAR_H * ROWS);
   localparam logic [10:0] X_OFF = 11'(X_POS);
   localparam logic [10:0] Y_OFF = 11'(Y_POS);

   logic [11:0] h_ext;
   logic [11:0] v_ext;
   logic        in_box;
   logic [6:0]  rel_x;
   logic [7:0]  rel_y;
   char_xy_t    xy;

   assign h_ext = {1'b0, hcount_in};
   assign v_ext = {1'b0, vcount_in};

   assign in_box = (h_ext >= X_LO) && (h_ext < X_HI) &&
                   (v_ext >= Y_LO) && (v_ext < Y_HI);

   // Only the low bits are meaningful inside the box.
   assign rel_x = 7'(hcount_in - X_OFF);
   assign rel_y = 8'(vcount_in - Y_OFF);

   // Text-ROM address, parked at 0 outside the box.
   always_comb begin
      xy = '0;
      if (in_box) begin
         xy.row = rel_y[7:4];
         xy.col = rel_x[6:3];
      end
   end

   assign char_xy = xy;

   vga_t vga_in;
   vga_t vga_s2;

   assign vga_in = '{hcount: hcount_in,
                     vcount: vcount_in,
                     hsync:  hsync_in,
                     vsync:  vsync_in,
                     hblnk:  hblnk_in,
                     vblnk:  vblnk_in,
                     rgb:    rgb_in};

   delay_pipe #(
      .W ($bits(vga_t)),
      .D (2)
   ) u_vga_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (vga_in),
      .q_o   (vga_s2)
   );

   logic       in_box_s1_q;
   logic [2:0] relx_s1_q;
   logic [3:0] rely_s1_q;
   logic       in_box_s2_q;
   logic [2:0] relx_s2_q;

   // Stage 1: glyph position while the text ROM answers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_box_s1_q <= 1'b0;
         relx_s1_q   <= '0;
         rely_s1_q   <= '0;
      end else begin
         in_box_s1_q <= in_box;
         relx_s1_q   <= rel_x[2:0];
         rely_s1_q   <= rel_y[3:0];
      end
   end

   assign font_addr = {char_code, rely_s1_q};

   // Stage 2: glyph column while the font ROM answers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_box_s2_q <= 1'b0;
         relx_s2_q   <= '0;
      end else begin
         in_box_s2_q <= in_box_s1_q;
         relx_s2_q   <= relx_s1_q;
      end
   end

   logic pix;
   logic blank;
   vga_t vga_d;
   vga_t vga_q;

   assign pix   = glyph_bit(font_data, relx_s2_q);
   assign blank = vga_s2.hblnk | vga_s2.vblnk;

   // Compose the pixel: glyph colour, optional fill, else pass-through.
   always_comb begin
      vga_d = vga_s2;
      if (in_box_s2_q && !blank) begin
         if (pix) begin
            vga_d.rgb = TXT_COLOR;
         end else if (BG_EN) begin
            vga_d.rgb = BG_COLOR;
         end
      end
   end

   // Stage 3: output register driving every port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_q <= '0;
      end else begin
         vga_q <= vga_d;
      end
   end

   assign hcount_out = vga_q.hcount;
   assign vcount_out = vga_q.vcount;
   assign hsync_out  = vga_q.hsync;
   assign vsync_out  = vga_q.vsync;
   assign hblnk_out  = vga_q.hblnk;
   assign vblnk_out  = vga_q.vblnk;
   assign rgb_out    = vga_q.rgb;

endmodule

// File: tb/tb_draw_text_box.sv
// Scoreboard bench for draw_text_box with text/font ROM models.
// Box at (100,50), 16x2 characters.
module tb_draw_text_box;

   localparam int          XP  = 100;
   localparam int          YP  = 50;
   localparam int          NC  = 16;
   localparam int          NR  = 2;
   localparam logic [11:0] TXT = 12'hF0F;
   localparam logic [11:0] BGC = 12'h00F;

`ifdef DRAW_TEXT_BG_EN
   localparam bit BG_EN = 1'b1;
`else
   localparam bit BG_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [10:0] hcount_in;
   logic [10:0] vcount_in;
   logic        hsync_in;
   logic        vsync_in;
   logic        hblnk_in;
   logic        vblnk_in;
   logic [11:0] rgb_in;
   logic [7:0]  char_xy;
   logic [6:0]  char_code;
   logic [10:0] font_addr;
   logic [7:0]  font_data;
   logic [10:0] hcount_out;
   logic [10:0] vcount_out;
   logic        hsync_out;
   logic        vsync_out;
   logic        hblnk_out;
   logic        vblnk_out;
   logic [11:0] rgb_out;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct {
      int          due;
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
   } exp_t;

   typedef struct {
      int          due;
      logic [10:0] fa;
   } fa_t;

   exp_t sbq[$];
   fa_t  faq[$];

   draw_text_box #(
      .X_POS     (XP),
      .Y_POS     (YP),
      .COLS      (NC),
      .ROWS      (NR),
      .TXT_COLOR (TXT),
      .BG_COLOR  (BGC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hcount_in  (hcount_in),
      .vcount_in  (vcount_in),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .hblnk_in   (hblnk_in),
      .vblnk_in   (vblnk_in),
      .rgb_in     (rgb_in),
      .char_xy    (char_xy),
      .char_code  (char_code),
      .font_addr  (font_addr),
      .font_data  (font_data),
      .hcount_out (hcount_out),
      .vcount_out (vcount_out),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out),
      .hblnk_out  (hblnk_out),
      .vblnk_out  (vblnk_out),
      .rgb_out    (rgb_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Column 5 of every row holds a space.
   function automatic logic [6:0] text_rom(input logic [7:0] xy);
      logic [7:0] s;
      if (xy[3:0] == 4'd5) return 7'h20;
      s = 8'h41 + xy;
      return s[6:0];
   endfunction

   // Space is blank; row 3 of any other glyph is 8'b1000_0000.
   function automatic logic [7:0] font_rom(input logic [10:0] a);
      logic [6:0] c;
      logic [3:0] r;
      c = a[10:4];
      r = a[3:0];
      if (c == 7'h20) return 8'h00;
      if (r == 4'd3) return 8'h80;
      return {c, 1'b1} ^ {r, r};
   endfunction

   always @(posedge clk) begin
      char_code <= text_rom(char_xy);
      font_data <= font_rom(font_addr);
   end

   function automatic bit inb_m(input int h, input int v);
      return h >= XP && h < XP + 8 * NC && v >= YP && v < YP + 16 * NR;
   endfunction

   function automatic logic [7:0] xy_m(input int h, input int v);
      logic [3:0] r;
      logic [3:0] c;
      if (!inb_m(h, v)) return 8'h00;
      r = 4'((v - YP) / 16);
      c = 4'((h - XP) / 8);
      return {r, c};
   endfunction

   function automatic logic [10:0] fa_m(input int h, input int v);
      logic [3:0] r;
      r = 4'(v - YP);
      return {text_rom(xy_m(h, v)), r};
   endfunction

   function automatic logic [11:0] rgb_m(
      input int h, input int v,
      input logic hb, input logic vb,
      input logic [11:0] rgb
   );
      logic [7:0] row;
      logic [3:0] r;
      if (!inb_m(h, v) || hb || vb) return rgb;
      r = 4'((v - YP) % 16);
      row = font_rom({text_rom(xy_m(h, v)), r});
      if (row[7 - ((h - XP) % 8)]) return TXT;
      return BG_EN ? BGC : rgb;
   endfunction

   // Scoreboard: pop entries when their output cycle arrives.
   always @(negedge clk) begin
      if (rst_n) begin
         while (faq.size() > 0 && faq[0].due <= cyc) begin
            fa_t f;
            f = faq.pop_front();
            vectors++;
            if (font_addr !== f.fa) begin
               miscompares++;
               $display("FAIL font_addr cyc=%0d: got %h want %h",
                        cyc, font_addr, f.fa);
            end
         end
         while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            vectors++;
            if ({rgb_out, hcount_out, vcount_out, hsync_out,
                 vsync_out, hblnk_out, vblnk_out} !==
                {e.rgb, e.h, e.v, e.hs, e.vs, e.hb, e.vb}) begin
               miscompares++;
               $display("FAIL pixel h=%0d v=%0d: got rgb=%h h=%0d v=%0d s=%b%b%b%b want rgb=%h s=%b%b%b%b",
                        e.h, e.v, rgb_out, hcount_out, vcount_out,
                        hsync_out, vsync_out, hblnk_out, vblnk_out,
                        e.rgb, e.hs, e.vs, e.hb, e.vb);
            end
         end
      end
   end

   // Called at posedge+1; returns at the next posedge+1.
   task automatic drive(
      input int h, input int v,
      input logic hs, input logic vs,
      input logic hb, input logic vb,
      input logic [11:0] rgb,
      input logic [11:0] er,
      input logic [7:0] exy
   );
      exp_t e;
      fa_t  f;
      hcount_in = 11'(h);
      vcount_in = 11'(v);
      hsync_in  = hs;
      vsync_in  = vs;
      hblnk_in  = hb;
      vblnk_in  = vb;
      rgb_in    = rgb;
      e = '{cyc + 3, 11'(h), 11'(v), hs, vs, hb, vb, er};
      f = '{cyc + 1, fa_m(h, v)};
      sbq.push_back(e);
      faq.push_back(f);
      #1;
      vectors++;
      if (char_xy !== exy) begin
         miscompares++;
         $display("FAIL char_xy h=%0d v=%0d: got %h want %h",
                  h, v, char_xy, exy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_m(
      input int h, input int v,
      input logic hb, input logic vb,
      input logic [11:0] rgb
   );
      drive(h, v, hb, vb, hb, vb, rgb,
            rgb_m(h, v, hb, vb, rgb), xy_m(h, v));
   endtask

   task automatic test_reset;
      int c0;
      rst_n = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         hcount_in = 11'($urandom);
         vcount_in = 11'($urandom);
         hsync_in  = 1'($urandom);
         vsync_in  = 1'($urandom);
         hblnk_in  = 1'($urandom);
         vblnk_in  = 1'($urandom);
         rgb_in    = 12'($urandom);
      end
      @(negedge clk);
      vectors++;
      if ({rgb_out, hcount_out, vcount_out, hsync_out,
           vsync_out, hblnk_out, vblnk_out} !== 38'd0) begin
         miscompares++;
         $display("FAIL reset_hold: got rgb=%h h=%0d v=%0d want 0",
                  rgb_out, hcount_out, vcount_out);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      c0 = cyc;
      drive(300, 400, 1'b1, 1'b1, 1'b1, 1'b1,
            12'hABC, 12'hABC, 8'h00);
      while (cyc < c0 + 2) @(negedge clk);
      vectors++;
      if (hcount_out !== 11'd0 || rgb_out !== 12'h000) begin
         miscompares++;
         $display("FAIL early_out: got h=%0d rgb=%h want 0",
                  hcount_out, rgb_out);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_addr;
      logic [11:0] er;
      er = BG_EN ? BGC : 12'h123;
      drive(117, 53, 1'b0, 1'b0, 1'b0, 1'b0,
            12'h123, er, 8'h02);
      vectors++;
      if (font_addr !== {7'h43, 4'd3}) begin
         miscompares++;
         $display("FAIL font_addr_direct: got %h want %h",
                  font_addr, {7'h43, 4'd3});
      end
   endtask

   task automatic test_glyph;
      logic [11:0] er;
      er = BG_EN ? BGC : 12'h456;
      drive(116, 53, 1'b0, 1'b0, 1'b0, 1'b0,
            12'h321, TXT, 8'h02);
      drive(117, 53, 1'b0, 1'b0, 1'b0, 1'b0,
            12'h456, er, 8'h02);
   endtask

   task automatic test_edges;
      drive(227, 53, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111,
            rgb_m(227, 53, 1'b0, 1'b0, 12'h111), 8'h0F);
      drive(228, 53, 1'b0, 1'b0, 1'b0, 1'b0, 12'h222,
            12'h222, 8'h00);
      drive(100, 53, 1'b0, 1'b0, 1'b0, 1'b0, 12'h333,
            TXT, 8'h00);
      drive(99, 53, 1'b0, 1'b0, 1'b0, 1'b0, 12'h444,
            12'h444, 8'h00);
      drive(116, 81, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555,
            rgb_m(116, 81, 1'b0, 1'b0, 12'h555), 8'h12);
      drive(116, 82, 1'b0, 1'b0, 1'b0, 1'b0, 12'h666,
            12'h666, 8'h00);
      drive(116, 49, 1'b0, 1'b0, 1'b0, 1'b0, 12'h777,
            12'h777, 8'h00);
   endtask

   task automatic test_blank;
      drive(116, 53, 1'b0, 1'b0, 1'b1, 1'b0,
            12'h7A7, 12'h7A7, 8'h02);
      drive(116, 53, 1'b0, 1'b0, 1'b0, 1'b1,
            12'h5B5, 12'h5B5, 8'h02);
      drive(140, 53, 1'b0, 1'b0, 1'b1, 1'b1,
            12'h3C3, 12'h3C3, 8'h05);
   endtask

   task automatic test_space;
      logic [11:0] er;
      er = BG_EN ? 12'h00F : 12'h9D9;
      drive(140, 53, 1'b0, 1'b0, 1'b0, 1'b0,
            12'h9D9, er, 8'h05);
      drive(147, 70, 1'b0, 1'b0, 1'b0, 1'b0,
            12'h8E8, BG_EN ? 12'h00F : 12'h8E8, 8'h15);
   endtask

   task automatic test_back_to_back;
      for (int h = 96; h < 110; h++)
         drive_m(h, 53, 1'b0, 1'b0, 12'($urandom));
      for (int h = 220; h < 232; h++)
         drive_m(h, 81, 1'b0, 1'b0, 12'($urandom));
      for (int i = 0; i < 60; i++)
         drive_m(int'($urandom_range(90, 240)),
                 int'($urandom_range(44, 90)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0),
                 12'($urandom));
   endtask

   task automatic test_mid_reset;
      for (int i = 0; i < 4; i++)
         drive_m(110 + i, 60, 1'b0, 1'b0, 12'hE0E);
      #2;
      rst_n = 1'b0;
      #1;
      sbq.delete();
      faq.delete();
      vectors++;
      if ({rgb_out, hcount_out, vcount_out, hsync_out,
           vsync_out, hblnk_out, vblnk_out} !== 38'd0) begin
         miscompares++;
         $display("FAIL mid_reset: got rgb=%h h=%0d want 0",
                  rgb_out, hcount_out);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++)
         drive_m(112 + i, 75, 1'b0, 1'b0, 12'h0D0);
   endtask

   task automatic drain;
      int n;
      n = 0;
      while ((sbq.size() > 0 || faq.size() > 0) && n < 10) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      if (sbq.size() > 0 || faq.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending want 0",
                  sbq.size() + faq.size());
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      hcount_in = '0;
      vcount_in = '0;
      hsync_in  = 1'b0;
      vsync_in  = 1'b0;
      hblnk_in  = 1'b0;
      vblnk_in  = 1'b0;
      rgb_in    = '0;
      test_reset();
      test_addr();
      test_glyph();
      test_edges();
      test_blank();
      test_space();
      test_back_to_back();
      test_mid_reset();
      drain();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
